// File: rtl/dkong3_dma_ctrl.sv
// Single-channel programmable block-transfer engine (copy or fill) for the sprite/work RAM ports.
// Bus is held via a request/acknowledge handshake; supports pause, abort and completion reporting.
module dkong3_dma_ctrl #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          I_TRIG,
  input  logic          I_ABORT,
  input  logic          I_MODE,
  input  logic [AW-1:0] I_SRC,
  input  logic [AW-1:0] I_DST,
  input  logic [AW:0]   I_LEN,
  input  logic [DW-1:0] I_FILL,
  input  logic          I_BUSAK,
  input  logic [DW-1:0] I_DS,
  output logic          O_BUSRQ,
  output logic [AW-1:0] O_AS,
  output logic [AW-1:0] O_AD,
  output logic [DW-1:0] O_DD,
  output logic          O_CES,
  output logic          O_CED,
  output logic          O_WE,
  output logic          O_BUSY,
  output logic          O_DONE,
  output logic          O_ABORTED
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          trig_q;
  logic [AW-1:0] src_q, dst_q;
  logic [AW:0]   cnt_q;
  logic          mode_q;
  logic [DW-1:0] fill_q, data_q;
  logic [2:0]    rd_cnt_q;
  logic          aborted_q;

  logic trig_acc, wr_fire, rd_last, last_byte, abort_end;

  // An edge arriving together with an abort is dropped rather than started.
  assign trig_acc  = (state_q == S_IDLE) && I_TRIG && !trig_q && !I_ABORT;
  assign wr_fire   = (state_q == S_WRITE) && I_BUSAK;
  assign rd_last   = (state_q == S_READ) && I_BUSAK && (rd_cnt_q == 3'(RD_LAT - 1));
  assign last_byte = (cnt_q == (AW+1)'(1));
  assign abort_end = I_ABORT && (((state_q == S_REQ) || (state_q == S_READ)) ||
                                 ((state_q == S_WRITE) && !(I_BUSAK && last_byte)));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (trig_acc) state_d = (I_LEN == '0) ? S_RELEASE : S_REQ;
      S_REQ: begin
        if (I_ABORT)      state_d = S_RELEASE;
        else if (I_BUSAK) state_d = mode_q ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (I_ABORT)      state_d = S_RELEASE;
        else if (rd_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (I_BUSAK) begin
          if (last_byte || I_ABORT) state_d = S_RELEASE;
          else                      state_d = mode_q ? S_WRITE : S_READ;
        end else if (I_ABORT) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_BUSRQ   = (state_q == S_REQ) || (state_q == S_READ) || (state_q == S_WRITE);
    O_CES     = (state_q == S_READ) && I_BUSAK;
    O_CED     = wr_fire;
    O_WE      = wr_fire;
    O_AS      = src_q;
    O_AD      = dst_q;
    O_DD      = mode_q ? fill_q : data_q;
    O_BUSY    = (state_q != S_IDLE);
    O_DONE    = (state_q == S_RELEASE);
    O_ABORTED = aborted_q;
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      trig_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      fill_q    <= '0;
      data_q    <= '0;
      rd_cnt_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      trig_q <= I_TRIG;
      if (trig_acc) begin
        src_q     <= I_SRC;
        dst_q     <= I_DST;
        cnt_q     <= I_LEN;
        mode_q    <= I_MODE;
        fill_q    <= I_FILL;
        rd_cnt_q  <= '0;
        aborted_q <= 1'b0;
      end
      if (abort_end) aborted_q <= 1'b1;
      // A paused read starts its latency count over once the bus returns.
      if (state_q == S_READ) begin
        if (!I_BUSAK) begin
          rd_cnt_q <= '0;
        end else if (rd_last) begin
          data_q   <= I_DS;
          rd_cnt_q <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + 3'd1;
        end
      end
      if (wr_fire) begin
        dst_q <= dst_q + AW'(1);
        if (!mode_q) src_q <= src_q + AW'(1);
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_dkong3_dma_ctrl.sv
// Directed bench for dkong3_dma_ctrl: copy, fill, zero length, pause, abort, retrigger and reset.
// Source RAM is a combinational model; writes are logged at the clock edge for later checking.
module tb_dkong3_dma_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0, abort = 1'b0, mode = 1'b0, pause = 1'b0;
  logic [AW-1:0] src = '0, dst = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill = '0;
  logic          busak;
  logic [DW-1:0] ds;
  logic          busrq, ces, ced, we, busy, done, aborted;
  logic [AW-1:0] as_o, ad_o;
  logic [DW-1:0] dd_o;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, wr_total = 0, done_total = 0, ces_total = 0, busrq_total = 0, busy_total = 0;
  int age = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];

  always #5 clk = ~clk;

  dkong3_dma_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .I_CLK(clk), .I_RST(rst), .I_TRIG(trig), .I_ABORT(abort), .I_MODE(mode),
    .I_SRC(src), .I_DST(dst), .I_LEN(len), .I_FILL(fill), .I_BUSAK(busak), .I_DS(ds),
    .O_BUSRQ(busrq), .O_AS(as_o), .O_AD(ad_o), .O_DD(dd_o), .O_CES(ces), .O_CED(ced),
    .O_WE(we), .O_BUSY(busy), .O_DONE(done), .O_ABORTED(aborted)
  );

  function automatic logic [DW-1:0] src_val(input logic [AW-1:0] a);
    return 8'(a * 37 + 11) ^ {6'd0, a[9:8]};
  endfunction

  assign ds = src_val(as_o);

  // Arbiter model: grant two cycles after the request, withheld while pause is set.
  always @(negedge clk) age <= busrq ? age + 1 : 0;
  assign busak = busrq && (age >= 2) && !pause;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we) begin
      wr_total <= wr_total + 1;
      wa_q.push_back(ad_o);
      wd_q.push_back(dd_o);
      wc_q.push_back(cyc);
    end
    if (done)  done_total  <= done_total + 1;
    if (ces)   ces_total   <= ces_total + 1;
    if (busrq) busrq_total <= busrq_total + 1;
    if (busy)  busy_total  <= busy_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                       input logic m, input logic [DW-1:0] f);
    @(negedge clk);
    src = s; dst = d; len = l; mode = m; fill = f; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_writes(input string tag, input int base, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (wr_total - base >= n) break;
      @(negedge clk);
    end
    check(tag, wr_total - base, n);
  endtask

  initial begin
    int wb, db, cb, rb, bb, bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busrq, ces, ced, we, busy, done, aborted}, 0);
    check("rst_addr", {as_o, ad_o, dd_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // DK3 default copy: 0x1A0 bytes from 0x100 to 0x000
    wb = wr_total; db = done_total; rb = busrq_total;
    start(10'h100, 10'h000, 11'h1A0, 1'b0, 8'h00);
    check("dk3_busy", busy, 1);
    wait_idle("dk3_idle", 2000);
    check("dk3_writes", wr_total - wb, 32'h1A0);
    check("dk3_done", done_total - db, 1);
    check("dk3_busrq_cyc", busrq_total - rb, 2 + 2 * 32'h1A0);
    bad = 0;
    for (int i = 0; i < 32'h1A0; i++)
      if (wa_q[wb+i] !== 10'(i) || wd_q[wb+i] !== src_val(10'(32'h100 + i))) bad++;
    check("dk3_data_errs", bad, 0);
    check("dk3_aborted", aborted, 0);

    // Fill with wrap-around at the top of the address space
    wb = wr_total; cb = ces_total;
    start(10'h000, 10'h3FE, 11'd4, 1'b1, 8'hA5);
    wait_idle("fill_idle", 50);
    check("fill_writes", wr_total - wb, 4);
    check("fill_addrs", {wa_q[wb], wa_q[wb+1], wa_q[wb+2], wa_q[wb+3]},
          {10'h3FE, 10'h3FF, 10'h000, 10'h001});
    check("fill_data", {wd_q[wb], wd_q[wb+1], wd_q[wb+2], wd_q[wb+3]}, 32'hA5A5A5A5);
    check("fill_consec", wc_q[wb+3] - wc_q[wb], 3);
    check("fill_no_ces", ces_total - cb, 0);

    // Zero length: no bus request, done one cycle after the trigger edge
    rb = busrq_total; db = done_total; bb = busy_total;
    start(10'h123, 10'h321, 11'd0, 1'b0, 8'h00);
    check("len0_done", {done, busy, busrq}, 3'b110);
    @(negedge clk);
    check("len0_after", {done, busy}, 2'b00);
    check("len0_busrq_cyc", busrq_total - rb, 0);
    check("len0_busy_cyc", busy_total - bb, 1);
    check("len0_done_cnt", done_total - db, 1);

    // Pause after write 3 of 8
    wb = wr_total; db = done_total;
    start(10'h010, 10'h200, 11'd8, 1'b0, 8'h00);
    wait_writes("pause_w3", wb, 3, 100);
    pause = 1'b1;
    cb = ces_total; bad = wr_total;
    repeat (5) begin
      @(negedge clk);
      check("pause_strobes", {ces, ced, we, busrq}, 4'b0001);
    end
    check("pause_no_wr", wr_total, bad);
    check("pause_no_rd", ces_total, cb);
    pause = 1'b0;
    wait_idle("pause_idle", 100);
    check("pause_writes", wr_total - wb, 8);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (wa_q[wb+i] !== 10'(32'h200 + i) || wd_q[wb+i] !== src_val(10'(32'h010 + i))) bad++;
    check("pause_data_errs", bad, 0);
    check("pause_done", done_total - db, 1);

    // Abort during the read of byte 10
    wb = wr_total; db = done_total;
    start(10'h300, 10'h080, 11'h20, 1'b0, 8'h00);
    wait_writes("abort_w9", wb, 9, 100);
    check("abort_in_read", ces, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("abort_idle", 20);
    check("abort_writes", wr_total - wb, 9);
    check("abort_flag", aborted, 1);
    check("abort_done", done_total - db, 1);
    start(10'h000, 10'h000, 11'd0, 1'b0, 8'h00);
    check("abort_cleared", aborted, 0);
    wait_idle("abort_idle2", 10);

    // Abort during the final write completes normally
    wb = wr_total;
    start(10'h000, 10'h055, 11'd1, 1'b1, 8'h3C);
    for (int i = 0; i < 20 && !we; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("lastwr_idle", 20);
    check("lastwr_writes", wr_total - wb, 1);
    check("lastwr_addr", wa_q[wb], 10'h055);
    check("lastwr_aborted", aborted, 0);

    // Retrigger while busy is ignored
    wb = wr_total; db = done_total;
    start(10'h040, 10'h140, 11'h10, 1'b0, 8'h00);
    wait_writes("retrig_w3", wb, 3, 100);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle("retrig_idle", 100);
    repeat (4) @(negedge clk);
    check("retrig_writes", wr_total - wb, 16);
    check("retrig_done", done_total - db, 1);
    check("retrig_still_idle", busy, 0);

    // Asynchronous reset mid-transfer
    wb = wr_total;
    start(10'h040, 10'h140, 11'h10, 1'b0, 8'h00);
    wait_writes("rstmid_w4", wb, 4, 100);
    for (int i = 0; i < 10 && !we; i++) @(negedge clk);
    check("rstmid_we_before", we, 1);
    db = done_total;
    #1 rst = 1'b1;
    #1;
    check("rstmid_async", {busrq, ces, ced, we, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_no_done", done_total - db, 0);
    check("rstmid_idle", {busy, aborted, busrq}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
